// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked pipelined adder.
// ADDER_CFG_CHECK stops elaboration on an illegal WIDTH/CHUNK pair.
package adder_pkg;

   localparam int unsigned MAX_W = 64;

   // One in-flight beat: the carry into the next slice, the sum bits produced so far
   // and the operand bits still waiting for their slice (right-aligned).
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [MAX_W-1:0] psum;
      logic [MAX_W-1:0] rem_a;
      logic [MAX_W-1:0] rem_b;
   } stage_t;

   // Adds the low w bits of a and b plus cin; bits [w:0] of the result are {cout, sum}.
   function automatic logic [MAX_W:0] chunk_add(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic             cin,
                                                input int unsigned      w);
      logic [MAX_W-1:0] m;
      m = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return {1'b0, a & m} + {1'b0, b & m} + (MAX_W+1)'(cin);
   endfunction

   function automatic bit cfg_ok(input int unsigned w, input int unsigned c);
      return (c >= 1) && (c <= w) && (w <= MAX_W) && ((w % c) == 0);
   endfunction

endpackage

`define ADDER_CFG_CHECK(W, C) \
   localparam bit CfgOk = adder_pkg::cfg_ok(W, C); \
   if (!CfgOk) begin : g_cfg_err \
      $fatal(1, "pipelined_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH <= 64"); \
   end

// File: rtl/adder_stage.sv
// One registered CHUNK-bit slice of the pipelined adder; holds when adv_i is low.
module adder_stage
   import adder_pkg::*;
#(
   parameter int unsigned CHUNK = 2,
   parameter int unsigned K     = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   adv_i,
   input  stage_t prev_i,
   output stage_t q_o
);

   stage_t         stage_d, stage_q;
   logic [MAX_W:0] r;

   always_comb begin
      r             = chunk_add(prev_i.rem_a, prev_i.rem_b, prev_i.carry, CHUNK);
      stage_d       = prev_i;
      stage_d.carry = r[CHUNK];
      stage_d.psum  = prev_i.psum | (MAX_W'(r[CHUNK-1:0]) << (K*CHUNK));
      // Consumed operand bits drop off so the next slice always reads bits [CHUNK-1:0].
      stage_d.rem_a = prev_i.rem_a >> CHUNK;
      stage_d.rem_b = prev_i.rem_b >> CHUNK;
   end

   always_ff @(posedge clk) begin
      if (rst)        stage_q <= '0;
      else if (adv_i) stage_q <= stage_d;
   end

   assign q_o = stage_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into WIDTH/CHUNK registered slices with valid/ready on both sides.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   `ADDER_CFG_CHECK(WIDTH, CHUNK)

   logic   adv;
   stage_t head;
   stage_t stage_out [STAGES];

   // The whole pipe moves as one; a bubble in the last stage never blocks it.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   always_comb begin
      head       = '0;
      head.valid = in_valid;
      head.carry = cin;
      head.rem_a = MAX_W'(a);
      head.rem_b = MAX_W'(b);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         adder_stage #(.CHUNK(CHUNK), .K(k)) u_stage (
            .clk(clk), .rst(rst), .adv_i(adv), .prev_i(head), .q_o(stage_out[k]));
      end else begin : g_next
         adder_stage #(.CHUNK(CHUNK), .K(k)) u_stage (
            .clk(clk), .rst(rst), .adv_i(adv), .prev_i(stage_out[k-1]), .q_o(stage_out[k]));
      end
   end

   assign out_valid = stage_out[STAGES-1].valid;
   assign sum       = stage_out[STAGES-1].psum[WIDTH-1:0];
   assign cout      = stage_out[STAGES-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
   // Carry into the MSB is sum_msb ^ a_msb ^ b_msb, so only a_msb ^ b_msb needs keeping.
   stage_t last_in;
   logic   axb_d, axb_q;

   if (STAGES == 1) begin : g_last_head
      assign last_in = head;
   end else begin : g_last_pipe
      assign last_in = stage_out[STAGES-2];
   end

   assign axb_d = last_in.rem_a[CHUNK-1] ^ last_in.rem_b[CHUNK-1];

   always_ff @(posedge clk) begin
      if (rst)      axb_q <= 1'b0;
      else if (adv) axb_q <= axb_d;
   end

   assign ovf = axb_q ^ sum[WIDTH-1] ^ cout;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 8/2 instance for directed cases, 4/2 instance swept exhaustively.
module tb_pipelined_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv1, ir1, c1, ov1, or1, co1;
   logic [7:0] a1, b1, s1;
   logic       iv2, ir2, c2, ov2, or2, co2;
   logic [3:0] a2, b2, s2;
`ifdef PIPELINED_ADDER_OVF_EN
   logic       ovf1, ovf2;
`endif

   int tests = 0;
   int fails = 0;
   int out_cnt1 = 0;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
   } exp_t;

   exp_t       q1[$];
   logic [4:0] q2[$];

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(c1),
      .out_valid(ov1), .out_ready(or1), .sum(s1),
`ifdef PIPELINED_ADDER_OVF_EN
      .ovf(ovf1),
`endif
      .cout(co1));

   pipelined_adder #(.WIDTH(4), .CHUNK(2)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(c2),
      .out_valid(ov2), .out_ready(or2), .sum(s2),
`ifdef PIPELINED_ADDER_OVF_EN
      .ovf(ovf2),
`endif
      .cout(co2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop and compare whenever a result is consumed.
   always @(negedge clk) begin
      exp_t e;
      if (rst) q1.delete();
      else if (ov1 && or1) begin
         out_cnt1++;
         if (q1.size() == 0) chk("spurious_out", 1, 0);
         else begin
            e = q1.pop_front();
            chk("sum", s1, e.s);
            chk("cout", co1, e.c);
`ifdef PIPELINED_ADDER_OVF_EN
            chk("ovf", ovf1, e.o);
`endif
         end
      end
   end

   always @(negedge clk) begin
      logic [4:0] e2;
      if (rst) q2.delete();
      else if (ov2 && or2) begin
         if (q2.size() == 0) chk("spurious_out4", 1, 0);
         else begin
            e2 = q2.pop_front();
            chk("ex_sum4", {co2, s2}, e2);
         end
      end
   end

   task automatic beat(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input logic eo);
      exp_t e;
      int   g;
      iv1 = 1'b1; a1 = ia; b1 = ib; c1 = ic;
      @(negedge clk);
      g = 0;
      while (!ir1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!ir1) chk("accept_timeout", 0, 1);
      else begin
         e.s = es; e.c = ec; e.o = eo;
         q1.push_back(e);
      end
      @(posedge clk); #1;
      iv1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         g, cnt0;
      logic       acc;
      rst = 1'b1;
      iv1 = 0; a1 = 0; b1 = 0; c1 = 0; or1 = 0;
      iv2 = 0; a2 = 0; b2 = 0; c2 = 0; or2 = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", ov1, 0);
      chk("rst_sum", s1, 0);
      chk("rst_cout", co1, 0);
      chk("rst_out_valid4", ov2, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", ir1, 1);
      @(posedge clk); #1;
      or1 = 1'b1;

      // Wrap-around and exact 4-cycle latency.
      beat(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("latency_out_valid", ov1, (i == 4));
      end
      @(posedge clk); #1;
      idle(2);

      // Back-to-back beats with concurrent accept and consume.
      beat(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0);
      beat(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
      beat(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      idle(6);

      // Backpressure: stall the head result for 3 cycles.
      beat(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      beat(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
      beat(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
      or1 = 1'b0;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!ov1 && g < 20);
      chk("bp_reached_out", ov1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", ir1, 0);
         chk("bp_sum_hold", s1, 8'h30);
         chk("bp_cout_hold", co1, 0);
      end
      @(posedge clk); #1;
      or1 = 1'b1;
      idle(8);
      chk("bp_queue_drained", q1.size(), 0);

      // Reset with three beats in flight: none may emerge.
      beat(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      beat(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0);
      beat(8'h03, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", ov1, 0);
      chk("midrst_sum", s1, 0);
      chk("midrst_cout", co1, 0);
      cnt0 = out_cnt1;
      idle(8);
      chk("midrst_no_old_beats", out_cnt1 - cnt0, 0);

      // Signed overflow case.
      beat(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      idle(6);
      chk("queue1_empty", q1.size(), 0);

      // Exhaustive 4-bit sweep with random backpressure.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               iv2 = 1'b1; a2 = 4'(ia); b2 = 4'(ib); c2 = 1'(ic);
               acc = 1'b0;
               g = 0;
               while (!acc && g < 64) begin
                  or2 = 1'($urandom_range(0, 1));
                  @(negedge clk);
                  if (ir2) begin
                     q2.push_back(5'(ia + ib + ic));
                     acc = 1'b1;
                  end
                  @(posedge clk); #1;
                  g++;
               end
               if (!acc) chk("accept_timeout4", 0, 1);
            end
         end
      end
      iv2 = 1'b0;
      or2 = 1'b1;
      idle(10);
      chk("queue4_empty", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
